// File: rtl/bcd_conv_scheduler_if.sv
// Requester/result and converter-side signal bundle for bcd_conv_scheduler.
// master = the scheduler, slave = requesters plus converter.
interface bcd_conv_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [9*NUM_REQ-1:0] req_BIN;
  logic [NUM_REQ-1:0]   ack;
  logic [3:0]           res_UND;
  logic [3:0]           res_DEC;
  logic [3:0]           res_CEN;
  logic [IDW-1:0]       res_id;
  logic                 res_valid;
  logic                 res_err;
  logic                 busy;
  logic                 conv_init;
  logic [8:0]           conv_BIN;
  logic                 conv_DONE;
  logic [3:0]           conv_UND;
  logic [3:0]           conv_DEC;
  logic [3:0]           conv_CEN;

  modport master (
    input  req, req_BIN,
    input  conv_DONE, conv_UND, conv_DEC, conv_CEN,
    output ack, res_UND, res_DEC, res_CEN,
    output res_id, res_valid, res_err, busy,
    output conv_init, conv_BIN
  );

  modport slave (
    output req, req_BIN,
    output conv_DONE, conv_UND, conv_DEC, conv_CEN,
    input  ack, res_UND, res_DEC, res_CEN,
    input  res_id, res_valid, res_err, busy,
    input  conv_init, conv_BIN
  );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter among requesters,
// with a watchdog that aborts conversions that never report done.
module bcd_conv_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  bcd_conv_scheduler_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, ISSUE, ARM, WAIT, CAPTURE, ABORT
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] res_id;
  logic [8:0]     conv_bin;
  logic [3:0]     und, dec, cen;
  logic [7:0]     wdog;
  logic           found;
  logic [IDW-1:0] pick;
  logic           wd_hit;
  logic [8:0]     ops [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign ops[g] = bus.req_BIN[9*g +: 9];
  end

  // First set request at or after rr_ptr, searching upward with wrap
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign wd_hit = (wdog == 8'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = ARM;
      ARM: begin
        if (!bus.conv_DONE) state_nx = WAIT;
        else if (wd_hit)    state_nx = ABORT;
      end
      WAIT: begin
        if (bus.conv_DONE) state_nx = CAPTURE;
        else if (wd_hit)   state_nx = ABORT;
      end
      CAPTURE: state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      res_id   <= '0;
      conv_bin <= '0;
      und      <= '0;
      dec      <= '0;
      cen      <= '0;
      wdog     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        res_id   <= pick;
        conv_bin <= ops[pick];
      end
      if (state == WAIT && bus.conv_DONE) begin
        und <= bus.conv_UND;
        dec <= bus.conv_DEC;
        cen <= bus.conv_CEN;
      end
      // Counter restarts on entry to each wait state
      if (state_nx != state &&
          (state_nx == ARM || state_nx == WAIT))
        wdog <= '0;
      else if (state == ARM || state == WAIT)
        wdog <= wdog + 8'd1;
      if (state == CAPTURE || state == ABORT)
        rr_ptr <= (res_id == IDW'(NUM_REQ - 1))
                  ? '0 : res_id + IDW'(1);
    end
  end

  assign bus.conv_init = (state == ISSUE);
  assign bus.conv_BIN  = conv_bin;
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = (state == CAPTURE);
  assign bus.res_err   = (state == ABORT);
  assign bus.res_id    = res_id;
  assign bus.res_UND   = und;
  assign bus.res_DEC   = dec;
  assign bus.res_CEN   = cen;
  assign bus.ack       = (state == CAPTURE || state == ABORT)
                         ? (NUM_REQ'(1) << res_id) : '0;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler with a behavioural converter model.
// Directed vectors push expected results; a monitor pops on each strobe.
module tb_bcd_conv_scheduler;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  bcd_conv_scheduler #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] cen;
    logic [3:0] dec;
    logic [3:0] und;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int init_cnt = 0;
  int init_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(int id, int c, int d, int u, bit err);
    exp_t x;
    x.id  = 2'(id);
    x.cen = 4'(c);
    x.dec = 4'(d);
    x.und = 4'(u);
    x.err = err;
    sb.push_back(x);
  endtask

  // Converter model: stale-done hold, latency, or never finishing
  int   lat = 3;
  int   stale = 0;
  bit   never = 1'b0;
  logic [8:0] op;
  int   run, drop;
  bit   running;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.conv_DONE <= 1'b0;
      bus.conv_UND  <= '0;
      bus.conv_DEC  <= '0;
      bus.conv_CEN  <= '0;
      running <= 1'b0;
      run <= 0;
      drop <= 0;
      op <= '0;
    end else if (bus.conv_init) begin
      op <= bus.conv_BIN;
      drop <= stale;
      run <= lat;
      running <= 1'b1;
    end else if (running) begin
      if (drop > 0) drop <= drop - 1;
      else begin
        bus.conv_DONE <= 1'b0;
        if (!never) begin
          if (run <= 1) begin
            bus.conv_DONE <= 1'b1;
            bus.conv_UND <= 4'(op % 10);
            bus.conv_DEC <= 4'((op / 10) % 10);
            bus.conv_CEN <= 4'(op / 100);
            running <= 1'b0;
          end else run <= run - 1;
        end
      end
    end
  end

  // Monitor
  exp_t e;
  bit   prev_init = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.conv_init) begin
        init_cnt <= init_cnt + 1;
        init_cyc <= cyc;
        if (prev_init) chk("init_width", 2, 1);
      end
      prev_init <= bus.conv_init;
      if (bus.res_valid || bus.res_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_id", int'(bus.res_id), int'(e.id));
          chk("res_err", int'(bus.res_err), int'(e.err));
          chk("res_valid", int'(bus.res_valid), int'(!e.err));
          chk("ack", int'(bus.ack), 1 << e.id);
          chk("digits", int'({bus.res_CEN, bus.res_DEC, bus.res_UND}),
              int'({e.cen, e.dec, e.und}));
        end
      end else if (bus.ack != 0) begin
        chk("ack_without_strobe", int'(bus.ack), 0);
      end
    end else begin
      prev_init <= 1'b0;
    end
  end

  task automatic set_op(int i, int v);
    bus.req_BIN[9*i +: 9] = 9'(v);
  endtask

  task automatic wait_acks(int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 2000) begin
      @(negedge clk);
      t++;
      if (|bus.ack) k++;
    end
    if (k < n) chk("ack_timeout", k, n);
  endtask

  task automatic wait_init();
    int t = 0;
    while (!bus.conv_init && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.conv_init) chk("init_timeout", 0, 1);
  endtask

  initial begin
    int i0, d;
    bus.req = '0;
    bus.req_BIN = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_init", int'(bus.conv_init), 0);
    chk("rst_bin", int'(bus.conv_BIN), 0);
    chk("rst_strobes", int'({bus.res_valid, bus.res_err}), 0);
    chk("rst_res", int'({bus.res_id, bus.res_CEN,
                         bus.res_DEC, bus.res_UND}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All four held: served 0,1,2,3,0
    set_op(0, 0); set_op(1, 9); set_op(2, 100); set_op(3, 511);
    push(0, 0, 0, 0, 0); push(1, 0, 0, 9, 0);
    push(2, 1, 0, 0, 0); push(3, 5, 1, 1, 0);
    push(0, 0, 0, 0, 0);
    bus.req = 4'b1111;
    wait_acks(5);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Single request id 1, operand 255
    set_op(1, 255);
    push(1, 2, 5, 5, 0);
    i0 = init_cnt;
    bus.req = 4'b0010;
    wait_acks(1);
    bus.req = '0;
    chk("init_pulses", init_cnt - i0, 1);
    repeat (2) @(negedge clk);

    // Serve id 2, then 0101 wraps to id 0 before id 2
    set_op(2, 42);
    push(2, 0, 4, 2, 0);
    bus.req = 4'b0100;
    wait_acks(1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    set_op(0, 7); set_op(2, 300);
    push(0, 0, 0, 7, 0); push(2, 3, 0, 0, 0);
    bus.req = 4'b0101;
    wait_acks(1);
    wait_acks(1);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Stale done held high across issue
    stale = 3;
    set_op(3, 123);
    push(3, 1, 2, 3, 0);
    bus.req = 4'b1000;
    wait_acks(1);
    bus.req = '0;
    stale = 0;
    repeat (2) @(negedge clk);

    // Converter never finishes: abort, digits unchanged
    never = 1'b1;
    set_op(0, 88);
    push(0, 1, 2, 3, 1);
    bus.req = 4'b0001;
    wait_init();
    i0 = cyc;
    wait_acks(1);
    bus.req = '0;
    d = cyc - i0;
    chk("timeout_window",
        int'(d >= TIMEOUT + 1 && d <= TIMEOUT + 3), 1);
    @(negedge clk);
    chk("busy_after_abort", int'(bus.busy), 0);
    never = 1'b0;
    set_op(1, 64);
    push(1, 0, 6, 4, 0);
    bus.req = 4'b0010;
    wait_acks(1);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset during WAIT; afterwards search restarts from id 0
    lat = 20;
    set_op(1, 77); set_op(2, 480);
    bus.req = 4'b0110;
    wait_init();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_ack", int'(bus.ack), 0);
    chk("arst_bin", int'(bus.conv_BIN), 0);
    chk("arst_strobes", int'({bus.res_valid, bus.res_err,
                              bus.conv_init}), 0);
    chk("arst_res", int'({bus.res_id, bus.res_CEN,
                          bus.res_DEC, bus.res_UND}), 0);
    repeat (2) @(negedge clk);
    lat = 3;
    push(1, 0, 7, 7, 0); push(2, 4, 8, 0, 0);
    rst = 1'b1;
    wait_acks(1);
    wait_acks(1);
    bus.req = '0;

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
